sine_freq_meter: RTL and testbench

Measures the frequency of the 6-bit signed sine stream produced by the DDS sine generator and returns a 9-bit frequency word in the same units as the generator's `Fo` input. It is the inverse of the generator: the generator turns `Fo` into a sine, and this block turns a sine back into `Fo`. It detects rising zero crossings with hysteresis, counts them over a fixed gate window, and also reports the period between the last two crossings. It sits at the signal-processing end of the chain and feeds the display and UART reporting paths.

---
 rtl/sine_freq_meter.sv | 141 ++++++++++++++
 tb/tb_sine_freq_meter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_freq_meter.sv
// Frequency meter for the 6-bit signed DDS sine stream: counts rising zero crossings per gate window.
// Latency: a crossing sample is reflected in the count and period_out at the next clk edge.
// No backpressure: freq_valid / period_valid are one-cycle pulses, and the outputs hold between pulses.
//
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   sample_in [5:0]  - two's-complement sine sample, qualified by sample_en
//   freq_out [8:0]   - crossings in the last completed gate (saturated at 511), with freq_valid,
//                      freq_ovf and signal_present
//   period_out       - clk cycles between the last two rising crossings, with period_valid
module sine_freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int HYST        = 4,
  parameter int PERIOD_W    = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          sample_in,
  input  logic                sample_en,
  output logic [8:0]          freq_out,
  output logic                freq_valid,
  output logic                freq_ovf,
  output logic                signal_present,
  output logic [PERIOD_W-1:0] period_out,
  output logic                period_valid
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  localparam logic signed [5:0] HYST_P = 6'(HYST);
  localparam logic signed [5:0] HYST_N = -HYST_P;

  localparam logic [1:0] ST_UNKNOWN = 2'd0;
  localparam logic [1:0] ST_POS     = 2'd1;
  localparam logic [1:0] ST_NEG     = 2'd2;

  localparam logic [9:0] CNT_SAT = 10'd511;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic                is_hi;
  logic                is_lo;
  logic                rise;
  logic [GW-1:0]       gate_cnt;
  logic                gate_last;
  logic [9:0]          cross_cnt;
  logic [9:0]          cross_nxt;
  logic                ovf_acc;
  logic                ovf_nxt;
  logic [PERIOD_W-1:0] per_cnt;
  logic                armed;

  assign is_hi = ($signed(sample_in) >= HYST_P);
  assign is_lo = ($signed(sample_in) <= HYST_N);

  // Hysteresis FSM. Only NEG -> POS is a crossing; leaving UNKNOWN is not,
  // so a stream that starts positive does not produce a spurious count.
  always_comb begin
    state_nxt = state;
    rise      = 1'b0;
    if (sample_en) begin
      case (state)
        ST_UNKNOWN: begin
          if (is_hi)      state_nxt = ST_POS;
          else if (is_lo) state_nxt = ST_NEG;
        end
        ST_NEG: begin
          if (is_hi) begin
            state_nxt = ST_POS;
            rise      = 1'b1;
          end
        end
        ST_POS: begin
          if (is_lo) state_nxt = ST_NEG;
        end
        default: state_nxt = ST_UNKNOWN;
      endcase
    end
  end

  assign gate_last = (gate_cnt == GATE_LAST);

  // Count including this cycle's crossing, so a crossing on the last gate
  // cycle lands in the window that is closing.
  assign cross_nxt = (rise && (cross_cnt < CNT_SAT)) ? cross_cnt + 10'd1 : cross_cnt;
  assign ovf_nxt   = ovf_acc | (cross_nxt == CNT_SAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_UNKNOWN;
      gate_cnt       <= '0;
      cross_cnt      <= '0;
      ovf_acc        <= 1'b0;
      freq_out       <= '0;
      freq_valid     <= 1'b0;
      freq_ovf       <= 1'b0;
      signal_present <= 1'b0;
    end else begin
      state      <= state_nxt;
      freq_valid <= 1'b0;
      if (gate_last) begin
        gate_cnt       <= '0;
        freq_out       <= cross_nxt[8:0];
        freq_ovf       <= ovf_nxt;
        signal_present <= (cross_nxt != 10'd0);
        freq_valid     <= 1'b1;
        cross_cnt      <= '0;
        ovf_acc        <= 1'b0;
      end else begin
        gate_cnt  <= gate_cnt + GW'(1);
        cross_cnt <= cross_nxt;
        ovf_acc   <= ovf_nxt;
      end
    end
  end

  // Period counter restarts at 1 on a crossing so that, at the next crossing,
  // it holds the exact number of clk edges between the two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt      <= '0;
      armed        <= 1'b0;
      period_out   <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (rise) begin
        per_cnt <= PERIOD_W'(1);
        armed   <= 1'b1;
        if (armed) begin
          period_out   <= per_cnt;
          period_valid <= 1'b1;
        end
      end else if (per_cnt != '1) begin
        per_cnt <= per_cnt + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sine_freq_meter.sv
// Bench for sine_freq_meter: directed sample patterns, expected pulses queued
// at stimulus time and checked by a negedge monitor (value and arrival step).
module tb_sine_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rst2_n = 1'b1;
  logic [5:0]  sample_in = '0;
  logic        sample_en = 1'b0;
  logic [5:0]  sample2 = '0;
  logic        en2 = 1'b0;

  logic [8:0]  freq_out, freq2_out;
  logic        freq_valid, freq2_valid;
  logic        freq_ovf, freq2_ovf;
  logic        signal_present, signal2_present;
  logic [23:0] period_out, period2_out;
  logic        period_valid, period2_valid;

  sine_freq_meter #(.GATE_CYCLES(1000), .HYST(4), .PERIOD_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_en(sample_en),
    .freq_out(freq_out), .freq_valid(freq_valid), .freq_ovf(freq_ovf),
    .signal_present(signal_present), .period_out(period_out), .period_valid(period_valid)
  );

  sine_freq_meter #(.GATE_CYCLES(2000), .HYST(4), .PERIOD_W(24)) dut2 (
    .clk(clk), .rst_n(rst2_n), .sample_in(sample2), .sample_en(en2),
    .freq_out(freq2_out), .freq_valid(freq2_valid), .freq_ovf(freq2_ovf),
    .signal_present(signal2_present), .period_out(period2_out), .period_valid(period2_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int v; int ovf; int pres; int at; } fexp_t;
  typedef struct { int v; int at; } pexp_t;

  fexp_t fq[$];
  fexp_t fq2[$];
  pexp_t pq[$];
  pexp_t pq2[$];

  int compared = 0;
  int mismatched = 0;
  int steps_done = 0;

  fexp_t fe;
  pexp_t pe;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (step %0d, t=%0t)", name, act, exp, steps_done, $time);
    end
  endtask

  task automatic unexpected(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: pulse at step %0d, expected none", name, steps_done);
  endtask

  // Monitor: every valid pulse must match the head of its queue.
  always @(negedge clk) begin
    if (freq_valid === 1'b1) begin
      if (fq.size() == 0) unexpected("freq_valid");
      else begin
        fe = fq.pop_front();
        chk("freq_out", int'(freq_out), fe.v);
        chk("freq_ovf", int'(freq_ovf), fe.ovf);
        chk("signal_present", int'(signal_present), fe.pres);
        chk("freq_at", steps_done, fe.at);
      end
    end
    if (period_valid === 1'b1) begin
      if (pq.size() == 0) unexpected("period_valid");
      else begin
        pe = pq.pop_front();
        chk("period_out", int'(period_out), pe.v);
        chk("period_at", steps_done, pe.at);
      end
    end
    if (freq2_valid === 1'b1) begin
      if (fq2.size() == 0) unexpected("freq2_valid");
      else begin
        fe = fq2.pop_front();
        chk("freq2_out", int'(freq2_out), fe.v);
        chk("freq2_ovf", int'(freq2_ovf), fe.ovf);
        chk("signal2_present", int'(signal2_present), fe.pres);
        chk("freq2_at", steps_done, fe.at);
      end
    end
    if (period2_valid === 1'b1) begin
      if (pq2.size() == 0) unexpected("period2_valid");
      else begin
        pe = pq2.pop_front();
        chk("period2_out", int'(period2_out), pe.v);
        chk("period2_at", steps_done, pe.at);
      end
    end
  end

  task automatic pushf(input int v, input int o, input int p, input int at);
    fe = '{v, o, p, at};
    fq.push_back(fe);
  endtask

  task automatic pushp(input int v, input int at);
    pe = '{v, at};
    pq.push_back(pe);
  endtask

  task automatic step(input int s, input bit e);
    sample_in = 6'(s);
    sample_en = e;
    @(posedge clk);
    #1;
    steps_done++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_freq_out"}, int'(freq_out), 0);
    chk({tag, "_freq_valid"}, int'(freq_valid), 0);
    chk({tag, "_freq_ovf"}, int'(freq_ovf), 0);
    chk({tag, "_signal_present"}, int'(signal_present), 0);
    chk({tag, "_period_out"}, int'(period_out), 0);
    chk({tag, "_period_valid"}, int'(period_valid), 0);
  endtask

  // Lets the monitor see any pulse from the last step, then asserts reset
  // and checks the outputs clear at once and stay clear.
  task automatic assert_reset(input int n);
    sample_en = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_now");
    for (int i = 0; i < n; i++) begin
      sample_in = 6'($urandom_range(0, 63));
      @(posedge clk);
      #1;
      chk_zero("rst_hold");
    end
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    steps_done = 0;
  endtask

  initial begin
    #2 rst2_n = 1'b0;

    // Reset with random samples.
    assert_reset(5);
    release_reset();

    // Nominal square wave, 100-cycle period, starting negative: rises at
    // k = 50 + 100j, first one only arms the period measurement.
    pushf(10, 0, 1, 1000);
    pushf(10, 0, 1, 2000);
    pushf(10, 0, 1, 3000);
    for (int k = 0; k < 3500; k++) begin
      if (k % 100 == 50 && k >= 150) pushp(100, k + 1);
      step((k % 100 < 50) ? -30 : 30, 1'b1);
    end

    // Reset mid-window (step 500 of the fourth gate), then restart.
    assert_reset(3);
    release_reset();
    pushf(10, 0, 1, 1000);
    for (int k = 0; k < 1000; k++) begin
      if (k % 100 == 50 && k >= 150) pushp(100, k + 1);
      step((k % 100 < 50) ? -30 : 30, 1'b1);
    end

    // Noise inside the hysteresis band.
    assert_reset(2);
    release_reset();
    pushf(0, 0, 0, 1000);
    for (int k = 0; k < 1000; k++) step((k % 2 == 0) ? 3 : -3, 1'b1);

    // Positive samples only ever arrive with sample_en low.
    assert_reset(2);
    release_reset();
    pushf(0, 0, 0, 1000);
    for (int k = 0; k < 1000; k++) begin
      if (k % 2 == 0) step(-30, 1'b1);
      else            step(30, 1'b0);
    end

    // Enable 1 in 2: positive edge at odd k=51+100j is seen at k+1.
    assert_reset(2);
    release_reset();
    pushf(10, 0, 1, 1000);
    for (int k = 0; k < 1000; k++) begin
      if (k % 100 == 52 && k >= 152) pushp(100, k + 1);
      step((k % 100 < 51) ? -30 : 30, (k % 2) == 0);
    end

    // Single crossing on the last gate cycle belongs to the closing window.
    assert_reset(2);
    release_reset();
    pushf(1, 0, 1, 1000);
    pushf(0, 0, 0, 2000);
    for (int k = 0; k < 2000; k++) step((k < 999) ? -30 : 30, 1'b1);

    // Saturation on the 2000-cycle instance, main instance held in reset.
    assert_reset(1);
    rst2_n = 1'b1;
    steps_done = 0;
    fe = '{511, 1, 1, 2000};
    fq2.push_back(fe);
    for (int k = 0; k < 2000; k++) begin
      if (k % 2 == 1 && k >= 3) begin
        pe = '{2, k + 1};
        pq2.push_back(pe);
      end
      sample2 = (k % 2 == 0) ? 6'(-30) : 6'(30);
      en2 = 1'b1;
      @(posedge clk);
      #1;
      steps_done++;
    end
    en2 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst2_n = 1'b0;

    // Any expected pulse still queued never arrived.
    while (fq.size() > 0)  begin fe = fq.pop_front();  unexpected_missing("freq_missing", fe.at); end
    while (pq.size() > 0)  begin pe = pq.pop_front();  unexpected_missing("period_missing", pe.at); end
    while (fq2.size() > 0) begin fe = fq2.pop_front(); unexpected_missing("freq2_missing", fe.at); end
    while (pq2.size() > 0) begin pe = pq2.pop_front(); unexpected_missing("period2_missing", pe.at); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  task automatic unexpected_missing(input string name, input int at);
    compared++;
    mismatched++;
    $display("FAIL %s: no pulse seen, expected one at step %0d", name, at);
  endtask

endmodule
